// File: rtl/wb_retry_master.sv
// Wishbone single-cycle initiator for address-only control slaves that signal busy with RTY.
// Accepts one request at a time from a local command port and runs a classic Wishbone cycle.
// On RTY it releases the bus for BACKOFF cycles and retries, up to MAX_RETRY retries.
// If an attempt gets neither ACK nor RTY within TIMEOUT cycles, the request is aborted.
//
// Ports:
//   CLK_I, RST_I                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o           command handshake (ready only in idle)
//   req_we_i, req_adr_i               command write flag and word address
//   ADR_O, CYC_O, STB_O, WE_O         Wishbone initiator outputs
//   ACK_I, RTY_I                      Wishbone slave responses
//   resp_valid_o                      one-cycle completion pulse
//   resp_status_o                     00 ok, 01 retries exhausted, 10 timeout
//   resp_retries_o                    number of RTYs received for the request
module wb_retry_master #(
  parameter int unsigned MAX_RETRY = 4,
  parameter int unsigned BACKOFF   = 2,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [29:0] req_adr_i,
  output logic [29:0] ADR_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  input  logic        RTY_I,
  output logic        resp_valid_o,
  output logic [1:0]  resp_status_o,
  output logic [3:0]  resp_retries_o
);

  localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);
  localparam logic [3:0] Backoff  = 4'(BACKOFF);
  localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusRetries = 2'b01;
  localparam logic [1:0] StatusTimeout = 2'b10;

  typedef enum logic [1:0] {StIdle, StBus, StBackoff, StResp} state_e;

  state_e      state_q;
  logic [3:0]  retry_cnt_q;
  logic [7:0]  tmo_cnt_q;
  logic [3:0]  bo_cnt_q;
  logic        ready_q;
  logic        cyc_q;
  logic        we_q;
  logic [29:0] adr_q;
  logic        resp_valid_q;
  logic [1:0]  status_q;
  logic [3:0]  retries_q;

  // Retry count including the RTY being sampled now; saturates at 15.
  logic [3:0]  retry_inc;
  assign retry_inc = (retry_cnt_q == 4'hF) ? 4'hF : retry_cnt_q + 4'd1;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= StIdle;
      retry_cnt_q  <= 4'd0;
      tmo_cnt_q    <= 8'd0;
      bo_cnt_q     <= 4'd0;
      ready_q      <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 30'd0;
      resp_valid_q <= 1'b0;
      status_q     <= 2'b00;
      retries_q    <= 4'd0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // ready_q is low for the first idle cycle after reset, so gate accept on it.
          if (req_valid_i && ready_q) begin
            adr_q       <= req_adr_i;
            we_q        <= req_we_i;
            retry_cnt_q <= 4'd0;
            tmo_cnt_q   <= 8'd0;
            cyc_q       <= 1'b1;
            ready_q     <= 1'b0;
            state_q     <= StBus;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StBus: begin
          if (ACK_I) begin
            status_q     <= StatusOk;
            retries_q    <= retry_cnt_q;
            resp_valid_q <= 1'b1;
            cyc_q        <= 1'b0;
            state_q      <= StResp;
          end else if (RTY_I && (retry_cnt_q == MaxRetry)) begin
            status_q     <= StatusRetries;
            retries_q    <= retry_inc;
            resp_valid_q <= 1'b1;
            cyc_q        <= 1'b0;
            state_q      <= StResp;
          end else if (RTY_I) begin
            retry_cnt_q <= retry_inc;
            bo_cnt_q    <= Backoff;
            cyc_q       <= 1'b0;
            state_q     <= StBackoff;
          end else if (tmo_cnt_q == TmoLast) begin
            status_q     <= StatusTimeout;
            retries_q    <= retry_cnt_q;
            resp_valid_q <= 1'b1;
            cyc_q        <= 1'b0;
            state_q      <= StResp;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        StBackoff: begin
          // Counter is loaded with BACKOFF, so leaving at 1 gives exactly BACKOFF idle cycles.
          if (bo_cnt_q <= 4'd1) begin
            tmo_cnt_q <= 8'd0;
            cyc_q     <= 1'b1;
            state_q   <= StBus;
          end else begin
            bo_cnt_q <= bo_cnt_q - 4'd1;
          end
        end
        StResp: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o    = ready_q;
  assign ADR_O          = adr_q;
  assign WE_O           = we_q;
  assign CYC_O          = cyc_q;
  assign STB_O          = cyc_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_status_o  = status_q;
  assign resp_retries_o = retries_q;

endmodule

// File: tb/tb_wb_retry_master.sv
module tb_wb_retry_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [29:0] req_adr;
  logic [29:0] adr_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic        ack;
  logic        rty;
  logic        rv;
  logic [1:0]  st;
  logic [3:0]  rt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_retry_master #(
    .MAX_RETRY(4),
    .BACKOFF  (2),
    .TIMEOUT  (16)
  ) dut (
    .CLK_I         (clk),
    .RST_I         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_adr_i     (req_adr),
    .ADR_O         (adr_o),
    .CYC_O         (cyc_o),
    .STB_O         (stb_o),
    .WE_O          (we_o),
    .ACK_I         (ack),
    .RTY_I         (rty),
    .resp_valid_o  (rv),
    .resp_status_o (st),
    .resp_retries_o(rt)
  );

  typedef struct {
    logic        rst, valid, we;
    logic [29:0] adr;
    logic        ack, rty;
    logic        e_ready, e_cyc, e_we;
    logic [29:0] e_adr;
    logic        e_rv;
    logic [1:0]  e_st;
    logic [3:0]  e_rt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic w, input logic [29:0] a,
                     input logic k, input logic y, input logic e_ready, input logic e_cyc,
                     input logic e_we, input logic [29:0] e_adr, input logic e_rv,
                     input logic [1:0] e_st, input logic [3:0] e_rt);
    vec_t x;
    x.rst = r; x.valid = v; x.we = w; x.adr = a; x.ack = k; x.rty = y;
    x.e_ready = e_ready; x.e_cyc = e_cyc; x.e_we = e_we; x.e_adr = e_adr;
    x.e_rv = e_rv; x.e_st = e_st; x.e_rt = e_rt;
    vecs.push_back(x);
  endtask

  // {ready, cyc, stb, we, adr, resp_valid, status, retries}
  function automatic logic [40:0] obs();
    return {req_ready, cyc_o, stb_o, we_o, adr_o, rv, st, rt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic w, input logic [29:0] a);
    req_valid = 1'b1;
    req_we    = w;
    req_adr   = a;
    step();
    req_valid = 1'b0;
  endtask

  localparam logic [29:0] A = 30'h0000123;
  localparam logic [29:0] B = 30'h2AAAAAAA;
  localparam logic [29:0] C = 30'h0ABCDEF;
  localparam logic [29:0] D = 30'h3FFFFFFF;

  initial begin
    int n;
    int att;
    int stray;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; ack = 1'b0; rty = 1'b0;

    // rst valid we adr ack rty | ready cyc we adr rv st rt
    add(1, 1, 1, A, 0, 0,   0, 0, 0, 0, 0, 0, 0);  // valid ignored in reset
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    // write, ACK on first bus cycle
    add(0, 1, 1, A, 0, 0,   0, 1, 1, A, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   0, 0, 1, A, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, A, 0, 0, 0);
    // ACK and RTY together: ACK wins, no backoff
    add(0, 1, 0, B, 0, 0,   0, 1, 0, B, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1,   0, 0, 0, B, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, B, 0, 0, 0);
    // RTY, RTY, ACK: cyc 1,0,0,1,0,0,1
    add(0, 1, 1, C, 0, 0,   0, 1, 1, C, 0, 0, 0);
    add(0, 1, 0, D, 0, 1,   0, 0, 1, C, 0, 0, 0);  // new request ignored while busy
    add(0, 0, 0, 0, 1, 1,   0, 0, 1, C, 0, 0, 0);  // ACK/RTY ignored in backoff
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, C, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, C, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, C, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, C, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,   0, 0, 1, C, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, C, 0, 0, 2);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req_valid = vecs[i].valid; req_we = vecs[i].we;
      req_adr = vecs[i].adr; ack = vecs[i].ack; rty = vecs[i].rty;
      step();
      check($sformatf("vec%0d", i), 64'(obs()),
            64'({vecs[i].e_ready, vecs[i].e_cyc, vecs[i].e_cyc, vecs[i].e_we, vecs[i].e_adr,
                 vecs[i].e_rv, vecs[i].e_st, vecs[i].e_rt}));
    end
    req_valid = 1'b0; ack = 1'b0; rty = 1'b0;

    // Slave always RTY: 5 attempts, 4 backoffs of 2 -> response in 14th cycle after accept.
    accept(1'b0, 30'h0001555);
    rty = 1'b1;
    n = 0; att = 0;
    for (int i = 1; i <= 60; i++) begin
      if (rv) begin n = i; break; end
      if (cyc_o) att++;
      step();
    end
    check("rty_attempts", 64'(att), 64'd5);
    check("rty_resp_cycle", 64'(n), 64'd14);
    check("rty_status", 64'({st, rt, req_ready}), 64'({2'b01, 4'd5, 1'b0}));
    rty = 1'b0;
    step();
    check("rty_ready_back", 64'({req_ready, rv}), 64'({1'b1, 1'b0}));

    // Silent slave: 16 consecutive bus cycles then timeout.
    accept(1'b1, 30'h0000777);
    n = 0; att = 0;
    for (int i = 1; i <= 60; i++) begin
      if (rv) begin n = i; break; end
      if (cyc_o) att++;
      step();
    end
    check("tmo_cyc_cycles", 64'(att), 64'd16);
    check("tmo_resp_cycle", 64'(n), 64'd17);
    check("tmo_status", 64'({st, rt, adr_o, we_o}), 64'({2'b10, 4'd0, 30'h0000777, 1'b1}));
    step();

    // Reset during backoff of the 2nd attempt.
    accept(1'b1, 30'h0000099);
    rty = 1'b1;
    step();
    rty = 1'b0;
    step();
    step();
    check("rst_attempt2", 64'(cyc_o), 64'd1);
    rty = 1'b1;
    step();
    rty = 1'b0;
    rst = 1'b1;
    step();
    check("rst_outputs", 64'(obs()), 64'd0);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rv || cyc_o) stray++;
    end
    check("rst_no_resp", 64'(stray), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    accept(1'b0, 30'h0000055);
    check("post_rst_bus", 64'({cyc_o, we_o, adr_o}), 64'({1'b1, 1'b0, 30'h0000055}));
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("post_rst_resp", 64'({rv, st, rt}), 64'({1'b1, 2'b00, 4'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_retry_master.md
# wb_retry_master

Wishbone single-cycle initiator that drives address-only control slaves (timer and similar peripherals that signal busy with RTY). It accepts one request at a time from a local command port and runs a classic Wishbone cycle. On RTY it releases the bus, backs off and retries up to a bounded count, and it aborts on a no-response timeout. It sits between a sequencer/CPU-side command source and the peripheral bus.

## Interface
- MAX_RETRY, 4: retries after the first attempt (total attempts = MAX_RETRY+1); range 0..15
- BACKOFF, 2: idle cycles with CYC_O low between attempts; range 1..15
- TIMEOUT, 16: cycles in an attempt without ACK/RTY before abort; range 1..255
- CLK_I  in  1  clock; all logic on rising edge
- RST_I  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  high only in IDLE; accept = req_valid_i & req_ready_o
- req_we_i  in  1  write (1) / read (0)
- req_adr_i  in  30  word address
- ADR_O  out  30  bus address
- CYC_O  out  1  bus cycle
- STB_O  out  1  strobe
- WE_O  out  1  write enable
- ACK_I  in  1  slave acknowledge
- RTY_I  in  1  slave retry
- resp_valid_o  out  1  one-cycle completion pulse
- resp_status_o  out  2  00 ok, 01 retries exhausted, 10 timeout; 11 never driven
- resp_retries_o  out  4  number of RTYs received for this request

## Operation
- States: IDLE, BUS, BACKOFF, RESP.
- IDLE: req_ready_o=1. On accept, latch adr/we into ADR_O/WE_O, clear retry_cnt and tmo_cnt, go to BUS.
- BUS: CYC_O=STB_O=1. Inputs are sampled at the edge.
  - ACK_I=1: status 00, go to RESP. ACK wins over a simultaneous RTY_I.
  - else RTY_I=1 with retry_cnt==MAX_RETRY: status 01, go to RESP; resp_retries_o reports MAX_RETRY+1.
  - else RTY_I=1: retry_cnt++, load backoff counter with BACKOFF, go to BACKOFF.
  - else tmo_cnt==TIMEOUT-1: status 10, go to RESP.
  - else tmo_cnt++.
- BACKOFF: CYC_O=STB_O=0. ADR_O/WE_O are held. Decrement the counter; when it reaches 1 (i.e. after BACKOFF cycles), clear tmo_cnt and go to BUS.
- RESP: resp_valid_o=1 for exactly one cycle, CYC_O=STB_O=0, then go to IDLE. There is no back-pressure on the response port.
- ADR_O/WE_O are stable from accept until the next accept. ACK_I/RTY_I are ignored outside BUS.
- retry_cnt saturates at 15 and is 4 bits wide. tmo_cnt is 8 bits, compared against TIMEOUT-1.

## Timing
- Reset values: req_ready_o=0 during reset, then 1 in IDLE; CYC_O=STB_O=WE_O=0; ADR_O=0; resp_valid_o=0; resp_status_o=00; resp_retries_o=0.
- Accept at edge k drives CYC_O/STB_O high in cycle k+1.
- ACK sampled at edge m gives resp_valid_o in cycle m+1 and req_ready_o in cycle m+2.
- Minimum request-to-request period is 3 cycles (IDLE, BUS, RESP).
- RTY at edge m:
  - CYC_O is low for cycles m+1..m+BACKOFF.
  - CYC_O is high again in cycle m+BACKOFF+1.
- Timeout with a silent slave: an attempt starting in cycle k times out at edge k+TIMEOUT-1, and resp_valid_o is high in cycle k+TIMEOUT.
- resp_status_o/resp_retries_o are valid while resp_valid_o=1 and hold their values until the next RESP.
- RST_I asserted in any state:
  - next edge goes to IDLE with all outputs at reset values;
  - an aborted request produces no response pulse;
  - CYC_O drops in the cycle after the reset edge.
- req_valid_i outside IDLE is ignored (not queued).

## Test plan
- Write, adr=0x0000123, slave ACKs in the first BUS cycle -> WE_O=1, ADR_O=0x0000123, resp_valid_o one cycle later with status 00, retries 0; CYC_O high exactly 1 cycle.
- Slave asserts RTY twice then ACK, BACKOFF=2 -> CYC_O pattern 1,0,0,1,0,0,1; response status 00, retries 2; ADR_O constant throughout.
- Slave always RTY, MAX_RETRY=4 -> 5 bus attempts; status 01, retries 5; req_ready_o returns high 2 cycles after the last RTY.
- Silent slave, TIMEOUT=16 -> CYC_O high 16 consecutive cycles, then status 10, retries 0.
- ACK_I and RTY_I both high in the same BUS cycle -> status 00, retries 0, no backoff.
- RST_I pulsed during BACKOFF of the 2nd attempt -> CYC_O stays 0, no resp_valid_o; a new request then completes normally with retries 0.
